// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback.
// Latency: outputs are a decode of the registered state; pcen also follows zero combinationally.
// No backpressure: advances one state per clock, unknown instructions fall back to FETCH.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               iord,
  output logic               memwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               memtoreg,
  output logic               regdst,
  output logic [2:0]         alucont,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    RTYPEEX = STATE_W'(6),
    RTYPEWB = STATE_W'(7),
    BEQEX   = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JEX     = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state, state_nxt;
  logic       pcwrite, branch;
  logic       op_ok, funct_ok;
  logic [2:0] funct_alu;

  assign state_o = state;
  assign pcen    = pcwrite | (branch & zero);

  // Classify op and funct; funct_alu is the ALU code for supported R-type functions.
  always_comb begin
    op_ok     = 1'b1;
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (op)
      OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      default:                                      op_ok = 1'b0;
    endcase
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH immediately, aborting any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Sticky flag for unknown opcodes and unknown R-type functions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal <= 1'b0;
    else if ((state == DECODE && !op_ok) || (state == RTYPEEX && !funct_ok))
      illegal <= 1'b1;
  end

  // Next-state logic and Moore control decode; everything idles at 0 and alucont at add.
  always_comb begin
    state_nxt = FETCH;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    irwrite   = 1'b0;
    iord      = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alucont   = 3'b010;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYP:      state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        alucont   = funct_alu;
        state_nxt = funct_ok ? RTYPEWB : FETCH;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        alucont = 3'b110;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, reset corner cases, random programs.
// Each instruction is checked state by state against an instruction-level sequence model.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, irwrite, iord, memwrite, regwrite, alusrca, memtoreg, regdst, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  logic [3:0] state_o;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .memtoreg(memtoreg), .regdst(regdst), .alucont(alucont), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic [2:0] alucont;
  } ctl_t;

  typedef struct {
    logic [5:0]      op;
    logic [5:0]      funct;
    logic            zero;
    int              n;
    logic [0:4][3:0] seq;
    logic            ill;
  } vec_t;

  ctl_t act_ctl;
  assign act_ctl = {pcen, irwrite, iord, memwrite, regwrite, alusrca, alusrcb,
                    pcsrc, memtoreg, regdst, alucont};

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Control word each state must present, taken from the per-state output list.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] fn, input logic z);
    ctl_t c;
    c = '0;
    c.alucont = 3'b010;
    case (st)
      4'd0:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1; end
      4'd1:  c.alusrcb = 2'b11;
      4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      4'd3:  c.iord = 1'b1;
      4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      4'd6: begin
        c.alusrca = 1'b1;
        case (fn)
          6'b100010: c.alucont = 3'b110;
          6'b100100: c.alucont = 3'b000;
          6'b100101: c.alucont = 3'b001;
          6'b101010: c.alucont = 3'b111;
          default:   c.alucont = 3'b010;
        endcase
      end
      4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      4'd8:  begin c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      4'd10: c.regwrite = 1'b1;
      4'd11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction-level model: which states an instruction visits and whether it is illegal.
  task automatic model_seq(input logic [5:0] o, input logic [5:0] fn,
                           output int n, output logic [0:4][3:0] s, output logic ill);
    logic fn_ok;
    fn_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
            (fn == 6'b100101) || (fn == 6'b101010);
    s   = '0;
    ill = 1'b0;
    case (o)
      6'b100011: begin n = 5; s = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; end
      6'b101011: begin n = 4; s = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}; end
      6'b000000: begin
        if (fn_ok) begin n = 4; s = {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}; end
        else begin n = 3; s = {4'd0, 4'd1, 4'd6, 4'd0, 4'd0}; ill = 1'b1; end
      end
      6'b000100: begin n = 3; s = {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}; end
      6'b001000: begin n = 4; s = {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}; end
      6'b000010: begin n = 3; s = {4'd0, 4'd1, 4'd11, 4'd0, 4'd0}; end
      default:   begin n = 2; s = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}; ill = 1'b1; end
    endcase
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 back in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] fn,
                           input logic z, input int n, input logic [0:4][3:0] s,
                           input logic ill);
    op = o; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".state"}, 32'(state_o), 32'(s[i]));
      chk({tag, ".ctl"}, 32'(act_ctl), 32'(exp_ctl(s[i], fn, z)));
      @(posedge clk); #1;
    end
    exp_ill = exp_ill | ill;
    chk({tag, ".ret_fetch"}, 32'(state_o), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
  endtask

  vec_t vecs[14];

  initial begin
    logic [0:4][3:0] s;
    int              n;
    logic            ill;
    logic [5:0]      ro, rf;
    logic            rz;
    logic [5:0]      ops[6];
    logic [5:0]      fns[5];

    vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0};
    vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 1'b0};
    vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0};
    vecs[3]  = '{6'b001000, 6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, 1'b0};
    vecs[4]  = '{6'b000010, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0}, 1'b0};
    vecs[5]  = '{6'b000100, 6'b000000, 1'b1, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 1'b0};
    vecs[6]  = '{6'b000100, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 1'b0};
    vecs[7]  = '{6'b000000, 6'b100010, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0};
    vecs[8]  = '{6'b000000, 6'b100100, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0};
    vecs[9]  = '{6'b000000, 6'b100101, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0};
    vecs[10] = '{6'b000000, 6'b101010, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0};
    vecs[11] = '{6'b111111, 6'b000000, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1};
    vecs[12] = '{6'b100011, 6'b000000, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0};
    vecs[13] = '{6'b000000, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd6, 4'd0, 4'd0}, 1'b1};

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset state: FETCH outputs shown while reset is held.
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    #3;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.ctl", 32'(act_ctl), 32'(exp_ctl(4'd0, 6'd0, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table: every instruction class, branch both ways, funct sweep, illegal cases.
    for (int i = 0; i < 14; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].funct, vecs[i].zero,
                vecs[i].n, vecs[i].seq, vecs[i].ill);

    // Reset asserted while in MEMRD: immediate return to FETCH, flag cleared, no writes.
    op = 6'b100011; funct = '0; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid.memrd", 32'(state_o), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid.state", 32'(state_o), 32'd0);
    chk("mid.illegal", 32'(illegal), 32'd0);
    chk("mid.nowrite", 32'({regwrite, memwrite}), 32'd0);
    @(posedge clk); #1;
    chk("mid.hold", 32'(state_o), 32'd0);
    reset = 1'b0;
    exp_ill = 1'b0;
    chk("rel.alusrcb", 32'(alusrcb), 32'd1);
    chk("rel.irwrite", 32'(irwrite), 32'd1);
    chk("rel.pcen", 32'(pcen), 32'd1);

    // Random program against the instruction-level model.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) ro = 6'($urandom);
      else                           ro = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) rf = 6'($urandom);
      else                           rf = fns[$urandom_range(0, 4)];
      rz = 1'($urandom);
      model_seq(ro, rf, n, s, ill);
      run_instr($sformatf("rnd%0d", i), ro, rf, rz, n, s, ill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
